// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: runtime-programmable clock divider controller.
// Accepts divide ratios over a valid/ready handshake, applies a new ratio or a
// stop only at an output period boundary, and reports the ratio in effect.
// Optional build macro FREQ_DIV_CTRL_ODD50_EN: 50% duty for odd ratios using a
// falling-edge re-register of the divided waveform.
module freq_div_ctrl #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [n-1:0] cfg_div,
  input  logic         cfg_stop,
  output logic         clk_out,
  output logic         tick,
  output logic         busy,
  output logic [n-1:0] cur_div,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [n-1:0] cnt, cnt_nxt;
  logic [n-1:0] cur_nxt;
  logic [n-1:0] pend_div, pend_div_nxt;
  logic         pend_stop, pend_stop_nxt;
  logic [n-1:0] half_nxt;
  logic         p, p_nxt;
  logic         tick_nxt, err_nxt, running_nxt;
  logic         accept, legal, wrap;

  assign accept = cfg_valid & cfg_ready;
  assign legal  = cfg_stop | (cfg_div >= n'(2));
  assign wrap   = (cnt == cur_div - n'(1));

  // The handshake and activity flags decode directly from the state register.
  assign cfg_ready = (state != PEND);
  assign busy      = (state != IDLE);

  // Next-state, next-count and next-ratio selection, plus the registered outputs' next values.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    cur_nxt       = cur_div;
    pend_div_nxt  = pend_div;
    pend_stop_nxt = pend_stop;
    err_nxt       = accept & ~legal;

    unique case (state)
      IDLE: begin
        // A stop while idle is accepted but has nothing to stop.
        if (accept && legal && !cfg_stop) begin
          state_nxt = RUN;
          cur_nxt   = cfg_div;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = wrap ? '0 : cnt + n'(1);
        if (accept && legal) begin
          state_nxt     = PEND;
          pend_div_nxt  = cfg_div;
          pend_stop_nxt = cfg_stop;
        end
      end
      PEND: begin
        // Old ratio keeps running; the stored request lands on the next boundary.
        cnt_nxt = wrap ? '0 : cnt + n'(1);
        if (wrap) begin
          if (pend_stop) begin
            state_nxt = IDLE;
            cur_nxt   = '0;
          end else begin
            state_nxt = RUN;
            cur_nxt   = pend_div;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cur_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase

    // High phase lasts ceil(N/2) counts of the ratio that will be in effect.
    half_nxt    = (cur_nxt >> 1) + {{(n-1){1'b0}}, cur_nxt[0]};
    running_nxt = (state_nxt != IDLE);
    p_nxt       = running_nxt && (cnt_nxt < half_nxt);
    tick_nxt    = running_nxt && (cnt_nxt == '0);
  end

  // State, counter, pending request and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_div   <= '0;
      pend_div  <= '0;
      pend_stop <= 1'b0;
      p         <= 1'b0;
      tick      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cur_div   <= cur_nxt;
      pend_div  <= pend_div_nxt;
      pend_stop <= pend_stop_nxt;
      p         <= p_nxt;
      tick      <= tick_nxt;
      err       <= err_nxt;
    end
  end

`ifdef FREQ_DIV_CTRL_ODD50_EN
  logic q;

  // Half-cycle delayed copy of the divided waveform, used to trim odd high phases.
  always_ff @(negedge clk) begin
    if (!rst) q <= 1'b0;
    else      q <= p;
  end

  // Both inputs are flops, and p & q only narrows a pulse that p already bounds.
  assign clk_out = cur_div[0] ? (p & q) : p;
`else
  assign clk_out = p;
`endif

endmodule
